// File: rtl/sdcard_pkg.sv
// Shared SD-card SPI-mode constants: command indices, R1 bits, lengths.
// Used by the card-side responder and the host-side command FSM.
package sdcard_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_COLLECT,
    ST_EVAL,
    ST_NCR,
    ST_RESP
  } resp_state_t;

  localparam logic [5:0] CMD_GO_IDLE    = 6'd0;
  localparam logic [5:0] CMD_SEND_IFC   = 6'd8;
  localparam logic [5:0] CMD_STOP_TRAN  = 6'd12;
  localparam logic [5:0] CMD_RD_SINGLE  = 6'd17;
  localparam logic [5:0] CMD_RD_MULTI   = 6'd18;
  localparam logic [5:0] ACMD_OP_COND   = 6'd41;
  localparam logic [5:0] CMD_APP_CMD    = 6'd55;
  localparam logic [5:0] CMD_READ_OCR   = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [2:0] LEN_R1 = 3'd1;
  localparam logic [2:0] LEN_R3 = 3'd5;
  localparam logic [2:0] LEN_R7 = 3'd5;

  function automatic logic [7:0] r1_byte(
    input logic idle,
    input logic illegal,
    input logic crc_err
  );
    logic [7:0] r;
    r = 8'h00;
    r[R1_IDLE] = idle;
    r[R1_ILLEGAL] = illegal;
    r[R1_CRC_ERR] = crc_err;
    return r;
  endfunction

endpackage

// File: rtl/sdcard_crc7.sv
// Byte-serial CRC7 (x^7 + x^3 + 1), MSB first, as used on SD command frames.
// init restarts the running value from zero with the current byte.
module sdcard_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  function automatic logic [6:0] step(
    input logic [6:0] c_in,
    input logic [7:0] d
  );
    logic [6:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= step(init ? 7'h00 : crc, data);
    end
  end

endmodule

// File: rtl/sdcard_spi_responder.sv
// Card-side SD SPI-mode command responder: frame capture, decode, R1/R3/R7.
// Define SDCARD_RESP_CRC_CHECK_EN to check the command CRC7.
module sdcard_spi_responder
  import sdcard_pkg::*;
#(
  parameter int          NCR_BYTES  = 1,
  parameter int          INIT_POLLS = 2,
  parameter logic [31:0] OCR_VALUE  = 32'h40FF8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs_n,
  input  logic        spi_byte_valid,
  input  logic [7:0]  spi_rx_data,
  output logic [7:0]  spi_tx_data,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  localparam logic [2:0] NCR_LAST = 3'(NCR_BYTES - 1);
  localparam logic [3:0] POLL_TGT = 4'(INIT_POLLS);

  resp_state_t state, state_nxt;

  logic [2:0]  byte_cnt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [39:0] resp_q;
  logic [2:0]  resp_len;
  logic [2:0]  resp_left;
  logic [2:0]  ncr_cnt;
  logic        idle_q;
  logic        app_q;
  logic [3:0]  polls_q;

  logic rx_ok;
  logic frame_start;
  logic collect_en;
  logic eval_en;
  logic ncr_adv;
  logic resp_adv;
  logic crc_err;

  assign rx_ok = spi_byte_valid & ~spi_cs_n;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (spi_cs_n) begin
      state_nxt = ST_HUNT;
    end else begin
      unique case (state)
        ST_HUNT:
          if (rx_ok && spi_rx_data[7:6] == 2'b01)
            state_nxt = ST_COLLECT;
        ST_COLLECT:
          if (rx_ok && byte_cnt == 3'd5)
            state_nxt = ST_EVAL;
        ST_EVAL:
          state_nxt = ST_NCR;
        ST_NCR:
          if (rx_ok && ncr_cnt == NCR_LAST)
            state_nxt = ST_RESP;
        ST_RESP:
          if (rx_ok && resp_left == 3'd0)
            state_nxt = ST_HUNT;
        default:
          state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    frame_start = 1'b0;
    collect_en  = 1'b0;
    eval_en     = 1'b0;
    ncr_adv     = 1'b0;
    resp_adv    = 1'b0;
    unique case (state)
      ST_HUNT:
        frame_start = rx_ok && spi_rx_data[7:6] == 2'b01;
      ST_COLLECT: collect_en = rx_ok;
      ST_EVAL:    eval_en = ~spi_cs_n;
      ST_NCR:     ncr_adv = rx_ok;
      ST_RESP:    resp_adv = rx_ok;
      default: ;
    endcase
  end

`ifdef SDCARD_RESP_CRC_CHECK_EN
  logic [6:0] crc_rx_q;
  logic [6:0] crc_calc;
  logic       crc_en;

  assign crc_en = frame_start |
                  (collect_en && byte_cnt != 3'd5);

  sdcard_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (frame_start),
    .en    (crc_en),
    .data  (spi_rx_data),
    .crc   (crc_calc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_rx_q <= 7'h00;
    end else if (collect_en && byte_cnt == 3'd5) begin
      crc_rx_q <= spi_rx_data[7:1];
    end
  end

  assign crc_err = crc_rx_q != crc_calc;
`else
  assign crc_err = 1'b0;
`endif

  logic        d_idle;
  logic        d_ready;
  logic [3:0]  d_polls;
  logic        d_app;
  logic        d_strobe;
  logic        d_illegal;
  logic [2:0]  d_len;
  logic [31:0] d_tail;
  logic [3:0]  polls_inc;
  logic [39:0] e_resp;
  logic [2:0]  e_len;

  assign polls_inc = (polls_q == 4'hF) ? polls_q : polls_q + 4'd1;

  always_comb begin
    d_idle    = idle_q;
    d_ready   = card_ready;
    d_polls   = polls_q;
    d_app     = 1'b0;
    d_strobe  = 1'b0;
    d_illegal = 1'b0;
    d_len     = LEN_R1;
    d_tail    = 32'hFFFF_FFFF;
    unique case (1'b1)
      idx_q == CMD_GO_IDLE: begin
        d_idle  = 1'b1;
        d_ready = 1'b0;
        d_polls = 4'd0;
      end
      idx_q == CMD_SEND_IFC: begin
        d_len  = LEN_R7;
        d_tail = {16'h0000, 4'h0, arg_q[11:0]};
      end
      idx_q == CMD_APP_CMD:
        d_app = 1'b1;
      idx_q == ACMD_OP_COND && app_q: begin
        d_polls = polls_inc;
        if (polls_inc >= POLL_TGT) begin
          d_idle  = 1'b0;
          d_ready = 1'b1;
        end
      end
      idx_q == CMD_READ_OCR: begin
        d_len  = LEN_R3;
        d_tail = {card_ready, OCR_VALUE[30:0]};
      end
      idx_q == CMD_STOP_TRAN ||
      idx_q == CMD_RD_SINGLE ||
      idx_q == CMD_RD_MULTI: begin
        d_illegal = idle_q;
        d_strobe  = ~idle_q;
      end
      default:
        d_illegal = 1'b1;
    endcase
  end

  // A CRC failure answers with the pre-command idle bit and executes nothing.
  always_comb begin
    e_resp = {r1_byte(d_idle, d_illegal, 1'b0), d_tail};
    e_len  = d_len;
    if (crc_err) begin
      e_resp = {r1_byte(idle_q, 1'b0, 1'b1), 32'hFFFF_FFFF};
      e_len  = LEN_R1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_tx_data <= 8'hFF;
      cmd_strobe  <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
      card_ready  <= 1'b0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      polls_q     <= 4'd0;
      byte_cnt    <= 3'd0;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= '1;
      resp_len    <= LEN_R1;
      resp_left   <= 3'd0;
      ncr_cnt     <= 3'd0;
    end else begin
      cmd_strobe <= 1'b0;
      if (spi_cs_n) spi_tx_data <= 8'hFF;
      if (frame_start) begin
        idx_q    <= spi_rx_data[5:0];
        byte_cnt <= 3'd1;
      end
      if (collect_en && byte_cnt != 3'd5) begin
        arg_q    <= {arg_q[23:0], spi_rx_data};
        byte_cnt <= byte_cnt + 3'd1;
      end
      if (eval_en) begin
        spi_tx_data <= 8'hFF;
        ncr_cnt     <= 3'd0;
        resp_q      <= e_resp;
        resp_len    <= e_len;
        if (!crc_err) begin
          idle_q     <= d_idle;
          card_ready <= d_ready;
          polls_q    <= d_polls;
          app_q      <= d_app;
          cmd_strobe <= d_strobe;
          cmd_index  <= idx_q;
          cmd_arg    <= arg_q;
        end
      end
      if (ncr_adv) begin
        if (ncr_cnt == NCR_LAST) begin
          spi_tx_data <= resp_q[39:32];
          resp_q      <= {resp_q[31:0], 8'hFF};
          resp_left   <= resp_len - 3'd1;
        end else begin
          ncr_cnt <= ncr_cnt + 3'd1;
        end
      end
      if (resp_adv) begin
        if (resp_left == 3'd0) begin
          spi_tx_data <= 8'hFF;
        end else begin
          spi_tx_data <= resp_q[39:32];
          resp_q      <= {resp_q[31:0], 8'hFF};
          resp_left   <= resp_left - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdcard_spi_responder.sv
// Scoreboard bench for sdcard_spi_responder: directed command frames,
// expected tx bytes and strobes queued, compared by independent monitors.
module tb_sdcard_spi_responder;

  localparam int NCR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs_n = 1'b0;
  logic        spi_byte_valid = 1'b0;
  logic [7:0]  spi_rx_data = 8'hFF;
  logic [7:0]  spi_tx_data;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_ready;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [37:0] strb_q[$];

  sdcard_spi_responder #(
    .NCR_BYTES  (NCR),
    .INIT_POLLS (2),
    .OCR_VALUE  (32'h40FF8000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_cs_n       (spi_cs_n),
    .spi_byte_valid (spi_byte_valid),
    .spi_rx_data    (spi_rx_data),
    .spi_tx_data    (spi_tx_data),
    .cmd_strobe     (cmd_strobe),
    .cmd_index      (cmd_index),
    .cmd_arg        (cmd_arg),
    .card_ready     (card_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // tx byte shifted out during a transfer = spi_tx_data before its valid edge
  always @(negedge clk) begin
    if (rst_n && spi_byte_valid && !spi_cs_n) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %h, required none", spi_tx_data);
      end else begin
        chk("tx_byte", {24'h0, spi_tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmd_strobe) begin
      if (strb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL strobe_unexpected: got idx %0d, required none",
                 cmd_index);
      end else begin
        logic [37:0] e;
        e = strb_q.pop_front();
        chk("strobe_index", {26'h0, cmd_index}, {26'h0, e[37:32]});
        chk("strobe_arg", cmd_arg, e[31:0]);
      end
    end
  end

  function automatic logic [6:0] crc7(input logic [39:0] f);
    logic [6:0] c;
    logic fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ f[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic send(input logic [7:0] b, input logic [7:0] e,
                      input bit track);
    if (track) exp_q.push_back(e);
    @(posedge clk);
    #1;
    spi_rx_data = b;
    spi_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    spi_byte_valid = 1'b0;
    spi_rx_data = 8'hFF;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame(input logic [5:0] idx, input logic [31:0] arg,
                       input bit bad_crc, input logic [39:0] rsp,
                       input int len);
    logic [39:0] f;
    logic [7:0]  c;
    f = {2'b01, idx, arg};
    c = bad_crc ? 8'h00 : {crc7(f), 1'b1};
    for (int i = 0; i < 5; i++) send(f[39-8*i -: 8], 8'hFF, 1'b1);
    send(c, 8'hFF, 1'b1);
    for (int i = 0; i < NCR; i++) send(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < len; i++) send(8'hFF, rsp[39-8*i -: 8], 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {24'h0, spi_tx_data}, 32'hFF);
    chk("rst_strobe", {31'h0, cmd_strobe}, 32'h0);
    chk("rst_index", {26'h0, cmd_index}, 32'h0);
    chk("rst_arg", cmd_arg, 32'h0);
    chk("rst_ready", {31'h0, card_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    frame(6'd0, 32'h0, 1'b0, {8'h01, 32'h0}, 1);
    frame(6'd8, 32'h000001AA, 1'b0, 40'h01000001AA, 5);
    frame(6'd17, 32'h00001234, 1'b0, {8'h05, 32'h0}, 1);
    chk("idle_cmd17_index", {26'h0, cmd_index}, 32'd17);

    frame(6'd55, 32'h0, 1'b0, {8'h01, 32'h0}, 1);
    frame(6'd41, 32'h40000000, 1'b0, {8'h01, 32'h0}, 1);
    chk("ready_after_poll1", {31'h0, card_ready}, 32'h0);
    frame(6'd55, 32'h0, 1'b0, {8'h01, 32'h0}, 1);
    frame(6'd41, 32'h40000000, 1'b0, {8'h00, 32'h0}, 1);
    chk("ready_after_poll2", {31'h0, card_ready}, 32'h1);

    frame(6'd58, 32'h0, 1'b0, 40'h00C0FF8000, 5);

    strb_q.push_back({6'd17, 32'h00001234});
    frame(6'd17, 32'h00001234, 1'b0, {8'h00, 32'h0}, 1);
    chk("cmd17_index", {26'h0, cmd_index}, 32'd17);
    chk("cmd17_arg", cmd_arg, 32'h00001234);

    strb_q.push_back({6'd18, 32'h00000200});
    frame(6'd18, 32'h00000200, 1'b0, {8'h00, 32'h0}, 1);

    frame(6'd41, 32'h0, 1'b0, {8'h04, 32'h0}, 1);
    chk("acmd41_noapp_ready", {31'h0, card_ready}, 32'h1);

    send(8'h40, 8'hFF, 1'b1);
    send(8'h00, 8'hFF, 1'b1);
    send(8'h00, 8'hFF, 1'b1);
    spi_cs_n = 1'b1;
    send(8'h00, 8'hFF, 1'b0);
    send(8'h95, 8'hFF, 1'b0);
    chk("cs_abort_tx", {24'h0, spi_tx_data}, 32'hFF);
    chk("cs_abort_ready", {31'h0, card_ready}, 32'h1);
    spi_cs_n = 1'b0;
    repeat (2) @(posedge clk);
    frame(6'd0, 32'h0, 1'b0, {8'h01, 32'h0}, 1);
    chk("cmd0_clears_ready", {31'h0, card_ready}, 32'h0);

`ifdef SDCARD_RESP_CRC_CHECK_EN
    frame(6'd0, 32'h0, 1'b1, {8'h09, 32'h0}, 1);
`else
    frame(6'd0, 32'h0, 1'b1, {8'h01, 32'h0}, 1);
`endif
    frame(6'd12, 32'h0, 1'b0, {8'h05, 32'h0}, 1);
    chk("hunt_tx_idle", {24'h0, spi_tx_data}, 32'hFF);

    repeat (5) @(posedge clk);
    chk("tx_queue_drained", exp_q.size(), 32'd0);
    chk("strobe_queue_drained", strb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdcard_spi_responder.md
SDCARD_SPI_RESPONDER -- requirements
Module: sdcard_spi_responder

Interface
REQ-001 SHALL have parameter NCR_BYTES, default 1, giving the number of 0xFF fill bytes between the command frame and the response (legal 1..8).
REQ-002 SHALL have parameter INIT_POLLS, default 2, giving the number of ACMD41 commands needed to leave idle (legal 1..15).
REQ-003 SHALL have parameter OCR_VALUE, default 32'h40FF8000, giving the OCR with the busy bit excluded.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 spi_cs_n  in  1  chip select from the SPI slave, active-low.
REQ-007 spi_byte_valid  in  1  one-clk pulse when a full byte has been received.
REQ-008 spi_rx_data  in  8  received byte, valid with spi_byte_valid.
REQ-009 spi_tx_data  out  8  registered byte the SPI slave shifts out during the next byte transfer.
REQ-010 cmd_strobe  out  1  one-clk pulse for an accepted CMD12, CMD17 or CMD18.
REQ-011 cmd_index  out  6  index of the last accepted command; held until the next command.
REQ-012 cmd_arg  out  32  argument of the last accepted command; held until the next command.
REQ-013 card_ready  out  1  1 once initialization has completed (card left idle).

Function
REQ-014 SHALL implement the states HUNT, COLLECT, EVAL, NCR and RESP.
REQ-015 HUNT: on spi_byte_valid with rx[7:6]==2'b01, SHALL capture index rx[5:0], set byte count to 1 and go to COLLECT; other bytes are ignored.
REQ-016 COLLECT: SHALL capture bytes 1-4 as the argument MSB-first and byte 5 as the CRC field; on byte 5 SHALL go to EVAL.
REQ-017 EVAL: SHALL take exactly one clk, build a response buffer of 1 or 5 bytes, then go to NCR.
REQ-018 spi_tx_data SHALL change only on edges where spi_byte_valid=1, on EVAL exit, or on reset/cs_n; it SHALL be 0xFF in every state except RESP.
REQ-019 Response timing SHALL be: NCR_BYTES bytes of 0xFF after command byte 5; the next byte carries resp[0] (loaded on the spi_byte_valid edge that ends the last NCR byte); each following spi_byte_valid advances to the next response byte; the valid after the final byte returns to HUNT with spi_tx_data=0xFF.
REQ-020 R1 byte SHALL be: bit0=idle state, bit2=illegal command, bit3=CRC error, all other bits 0.
REQ-021 CMD0 SHALL enter idle, clear card_ready, reset the ACMD41 poll counter and return R1.
REQ-022 CMD8 SHALL return R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
REQ-023 CMD55 SHALL return R1 and set an app flag; any other command SHALL clear the app flag after being decoded.
REQ-024 ACMD41 (index 41 with app flag set) SHALL increment the poll counter (saturating); when the counter reaches INIT_POLLS, idle SHALL clear and card_ready SHALL set; the returned R1 SHALL reflect idle after this update.
REQ-025 CMD58 SHALL return R3 = R1, then OCR_VALUE with bit31 = card_ready, MSB-first.
REQ-026 CMD12/17/18 SHALL return R1 and pulse cmd_strobe in EVAL; the pulse SHALL be suppressed while idle, in which case the illegal bit is set.
REQ-027 Index 41 without the app flag, and any other index, SHALL return R1 with the illegal bit set and no state change.
REQ-028 cmd_index and cmd_arg SHALL update in EVAL for every decoded command.
REQ-029 spi_cs_n=1 in any state SHALL force HUNT and spi_tx_data=0xFF on the next edge, and SHALL abandon a partial frame or response; idle, card_ready and the poll counter are kept.
REQ-030 A spi_byte_valid while spi_cs_n=1 SHALL be ignored.

Reset
REQ-031 On rst_n=0 the outputs SHALL reset to: state HUNT, spi_tx_data=0xFF, cmd_strobe=0, cmd_index=0, cmd_arg=0, card_ready=0.
REQ-032 On rst_n=0 the internal state SHALL reset to: idle=1, app flag=0, poll counter=0; reset mid-frame discards the frame.

Configuration
REQ-033 With SDCARD_RESP_CRC_CHECK_EN defined, EVAL SHALL compare the received CRC7 (byte5[7:1]) with the CRC7 computed over bytes 0-4; on mismatch it SHALL return R1 with the CRC bit set and SHALL NOT execute the command.
REQ-034 Without SDCARD_RESP_CRC_CHECK_EN, the CRC field SHALL be ignored, the CRC bit SHALL always be 0, and no CRC logic SHALL be synthesized.

Structure
REQ-035 Command index constants, R1 bit positions and response lengths SHALL live in shared package sdcard_pkg, also used by the host-side command FSM.
REQ-036 CRC7 SHALL be a sub-module sdcard_crc7 (byte-serial, polynomial x^7+x^3+1), instantiated only under SDCARD_RESP_CRC_CHECK_EN.

Verification
REQ-037 CMD0 frame 40 00 00 00 00 95 then 2 bytes of 0xFF -> tx sequence FF (NCR), 01; then HUNT.
REQ-038 CMD8 frame 48 00 00 01 AA 87 -> tx after NCR = 01 00 00 01 AA.
REQ-039 From idle, two CMD55+ACMD41 pairs (arg 40000000) -> first ACMD41 R1=01, second R1=00 with card_ready=1; then CMD58 -> 00 C0 FF 80 00.
REQ-040 CMD17 arg 0x00001234 when ready -> R1=00, cmd_strobe single pulse, cmd_index=17, cmd_arg=0x00001234; CMD17 while idle -> R1=05, no strobe.
REQ-041 spi_cs_n raised after byte 3 of a frame, then a full CMD0 frame -> only the CMD0 response appears; state is consistent.
REQ-042 With the CRC macro defined, CMD0 with CRC byte 0x00 -> R1=09 and idle is unchanged; without the macro -> R1=01.
